mem_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite style arbiter that shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store path of the execute stage (LSU, read and write). It grants one complete transaction at a time (address phase through response), routes the granted master's channels to the slave, and holds all other requests off. It sits between the IFU/EXU handshake ports and the memory slave that serves `pmem_read`/`pmem_write`.

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master, one-slave AXI4-Lite style arbiter for the shared data-memory port.
// IFU (read-only) and LSU (read/write) get one complete transaction per grant.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [1:0]  lsu_bresp,
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_awaddr,
    output logic        s_wvalid,
    input  logic        s_wready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_bvalid,
    output logic        s_bready,
    input  logic [1:0]  s_bresp,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IFU_RD = 2'b01,
        LSU_RD = 2'b10,
        LSU_WR = 2'b11
    } state_t;

    state_t state;
    logic   last_lsu;
    logic   ar_done;
    logic   aw_done;
    logic   w_done;

    logic   req_ifu;
    logic   req_lsu;
    logic   own_ifu;
    logic   own_lrd;
    logic   own_wr;
    logic   ar_hs;
    logic   aw_hs;
    logic   w_hs;
    logic   b_ok;
    logic   r_hs;
    logic   b_hs;

    assign req_ifu = ifu_arvalid;
    assign req_lsu = lsu_arvalid | lsu_awvalid;
    assign own_ifu = (state == IFU_RD);
    assign own_lrd = (state == LSU_RD);
    assign own_wr  = (state == LSU_WR);

    // Handshakes are derived from inputs only, keeping the comb paths acyclic
    assign ar_hs = ~ar_done & s_arready
                 & ((own_ifu & ifu_arvalid) | (own_lrd & lsu_arvalid));
    assign aw_hs = own_wr & ~aw_done & lsu_awvalid & s_awready;
    assign w_hs  = own_wr & ~w_done & lsu_wvalid & s_wready;
    assign b_ok  = (aw_done | aw_hs) & (w_done | w_hs);
    assign r_hs  = s_rvalid
                 & ((own_ifu & ifu_rready) | (own_lrd & lsu_rready));
    assign b_hs  = own_wr & b_ok & s_bvalid & lsu_bready;

    assign grant = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_lsu <= 1'b1;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ifu && (!req_lsu || last_lsu)) begin
                        state    <= IFU_RD;
                        last_lsu <= 1'b0;
                    end else if (req_lsu) begin
                        state    <= lsu_awvalid ? LSU_WR : LSU_RD;
                        last_lsu <= 1'b1;
                    end
                end
                IFU_RD, LSU_RD: begin
                    if (r_hs) begin
                        state   <= IDLE;
                        ar_done <= 1'b0;
                    end else if (ar_hs) begin
                        ar_done <= 1'b1;
                    end
                end
                LSU_WR: begin
                    if (b_hs) begin
                        state   <= IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = '0;
        s_arvalid   = 1'b0;
        s_araddr    = '0;
        s_rready    = 1'b0;
        s_awvalid   = 1'b0;
        s_awaddr    = '0;
        s_wvalid    = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_bready    = 1'b0;
        case (state)
            IFU_RD: begin
                s_arvalid   = ifu_arvalid & ~ar_done;
                s_araddr    = ifu_araddr;
                ifu_arready = s_arready & ~ar_done;
                ifu_rvalid  = s_rvalid;
                ifu_rdata   = s_rdata;
                ifu_rresp   = s_rresp;
                s_rready    = ifu_rready;
            end
            LSU_RD: begin
                s_arvalid   = lsu_arvalid & ~ar_done;
                s_araddr    = lsu_araddr;
                lsu_arready = s_arready & ~ar_done;
                lsu_rvalid  = s_rvalid;
                lsu_rdata   = s_rdata;
                lsu_rresp   = s_rresp;
                s_rready    = lsu_rready;
            end
            LSU_WR: begin
                s_awvalid   = lsu_awvalid & ~aw_done;
                s_awaddr    = lsu_awaddr;
                lsu_awready = s_awready & ~aw_done;
                s_wvalid    = lsu_wvalid & ~w_done;
                s_wdata     = lsu_wdata;
                s_wstrb     = lsu_wstrb;
                lsu_wready  = s_wready & ~w_done;
                // B is only exposed once both write beats are in
                lsu_bvalid  = s_bvalid & b_ok;
                lsu_bresp   = s_bresp;
                s_bready    = lsu_bready & b_ok;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a queue-based scoreboard.
// Grants and master responses are checked by a negedge monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_arvalid = 0, ifu_arready;
    logic [31:0] ifu_araddr = 0;
    logic        ifu_rvalid, ifu_rready = 0;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid = 0, lsu_arready;
    logic [31:0] lsu_araddr = 0;
    logic        lsu_rvalid, lsu_rready = 0;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid = 0, lsu_awready;
    logic [31:0] lsu_awaddr = 0;
    logic        lsu_wvalid = 0, lsu_wready;
    logic [31:0] lsu_wdata = 0;
    logic [3:0]  lsu_wstrb = 0;
    logic        lsu_bvalid, lsu_bready = 0;
    logic [1:0]  lsu_bresp;
    logic        s_arvalid, s_arready = 0;
    logic [31:0] s_araddr;
    logic        s_rvalid = 0, s_rready;
    logic [31:0] s_rdata = 0;
    logic [1:0]  s_rresp = 0;
    logic        s_awvalid, s_awready = 0;
    logic [31:0] s_awaddr;
    logic        s_wvalid, s_wready = 0;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid = 0, s_bready;
    logic [1:0]  s_bresp = 0;
    logic [1:0]  grant;

    localparam logic [1:0] EV_GNT = 2'd0;
    localparam logic [1:0] EV_IFU = 2'd1;
    localparam logic [1:0] EV_LSR = 2'd2;
    localparam logic [1:0] EV_LSB = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [33:0] val;
    } ev_t;

    ev_t         sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  prev_grant = 2'b00;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_araddr(lsu_araddr),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_awaddr(lsu_awaddr),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .lsu_bresp(lsu_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bresp(s_bresp),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [1:0] k, input logic [33:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [33:0] act,
                       input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic observe(input logic [1:0] k, input logic [33:0] v,
                           input string nm);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected act=%h", nm, v);
        end else begin
            e = sb.pop_front();
            if (e.kind !== k || e.val !== v) begin
                failures++;
                $display("FAIL %s act=%0d/%h exp=%0d/%h",
                         nm, k, v, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (grant != 2'b00 && grant != prev_grant)
                observe(EV_GNT, {32'b0, grant}, "grant");
            if (ifu_rvalid && ifu_rready)
                observe(EV_IFU, {ifu_rresp, ifu_rdata}, "ifu_r");
            if (lsu_rvalid && lsu_rready)
                observe(EV_LSR, {lsu_rresp, lsu_rdata}, "lsu_r");
            if (lsu_bvalid && lsu_bready)
                observe(EV_LSB, {lsu_bresp, 32'b0}, "lsu_b");
            prev_grant = grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_grant", {32'b0, grant}, 34'd0);
        chk("rst_s_arvalid", {33'b0, s_arvalid}, 34'd0);
        chk("rst_s_awvalid", {33'b0, s_awvalid}, 34'd0);
        rst = 1'b0;

        // IFU read alone
        tick();
        push(EV_GNT, 34'd1);
        push(EV_IFU, {2'b00, 32'h0010_0093});
        ifu_arvalid = 1;
        ifu_araddr  = 32'h8000_0000;
        ifu_rready  = 1;
        s_arready   = 1;
        tick();
        #1;
        chk("t1_araddr", {2'b0, s_araddr}, {2'b0, 32'h8000_0000});
        chk("t1_arvalid", {33'b0, s_arvalid}, 34'd1);
        tick();
        ifu_arvalid = 0;
        s_arready   = 0;
        s_rvalid    = 1;
        s_rdata     = 32'h0010_0093;
        s_rresp     = 2'b00;
        #1;
        chk("t1_ifu_rvalid", {33'b0, ifu_rvalid}, 34'd1);
        tick();
        s_rvalid = 0;
        #1;
        chk("t1_idle", {32'b0, grant}, 34'd0);

        // LSU write, AW accepted one cycle before W
        tick();
        push(EV_GNT, 34'd3);
        push(EV_LSB, 34'd0);
        lsu_awvalid = 1;
        lsu_awaddr  = 32'h8000_1000;
        lsu_wvalid  = 1;
        lsu_wdata   = 32'hDEAD_BEEF;
        lsu_wstrb   = 4'hF;
        lsu_bready  = 1;
        s_awready   = 1;
        s_wready    = 0;
        tick();
        #1;
        chk("t2_awvalid", {33'b0, s_awvalid}, 34'd1);
        chk("t2_awaddr", {2'b0, s_awaddr}, {2'b0, 32'h8000_1000});
        tick();
        s_wready = 1;
        #1;
        chk("t2_aw_forced", {33'b0, s_awvalid}, 34'd0);
        chk("t2_awready_forced", {33'b0, lsu_awready}, 34'd0);
        chk("t2_wdata", {2'b0, s_wdata}, {2'b0, 32'hDEAD_BEEF});
        chk("t2_wstrb", {30'b0, s_wstrb}, 34'hF);
        tick();
        lsu_awvalid = 0;
        lsu_wvalid  = 0;
        s_awready   = 0;
        s_wready    = 0;
        s_bvalid    = 1;
        s_bresp     = 2'b00;
        tick();
        s_bvalid = 0;
        #1;
        chk("t2_idle", {32'b0, grant}, 34'd0);

        // Simultaneous reads after reset alternate 01,10,01,10
        tick();
        rst = 1;
        tick();
        rst = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            push(EV_GNT, 34'd1);
            push(EV_IFU, {2'b01, 32'h1111_2222});
            push(EV_GNT, 34'd2);
            push(EV_LSR, {2'b01, 32'h1111_2222});
        end
        ifu_arvalid = 1;
        lsu_arvalid = 1;
        ifu_rready  = 1;
        lsu_rready  = 1;
        s_arready   = 1;
        s_rvalid    = 1;
        s_rdata     = 32'h1111_2222;
        s_rresp     = 2'b01;
        repeat (7) tick();
        ifu_arvalid = 0;
        lsu_arvalid = 0;
        tick();
        s_rvalid = 0;
        #1;
        chk("t3_idle", {32'b0, grant}, 34'd0);

        // LSU requests while IFU read is in flight
        tick();
        push(EV_GNT, 34'd1);
        push(EV_IFU, {2'b00, 32'hAAAA_0001});
        push(EV_GNT, 34'd2);
        push(EV_LSR, {2'b00, 32'hBBBB_0002});
        ifu_arvalid = 1;
        ifu_araddr  = 32'h8000_0004;
        s_rresp     = 2'b00;
        tick();
        lsu_arvalid = 1;
        lsu_araddr  = 32'h8000_2000;
        #1;
        chk("t4_lsu_arready_a", {33'b0, lsu_arready}, 34'd0);
        chk("t4_araddr", {2'b0, s_araddr}, {2'b0, 32'h8000_0004});
        tick();
        ifu_arvalid = 0;
        s_rvalid    = 1;
        s_rdata     = 32'hAAAA_0001;
        #1;
        chk("t4_lsu_arready_b", {33'b0, lsu_arready}, 34'd0);
        chk("t4_lsu_rvalid", {33'b0, lsu_rvalid}, 34'd0);
        tick();
        s_rvalid = 0;
        #1;
        chk("t4_gap", {32'b0, grant}, 34'd0);
        tick();
        s_rvalid = 1;
        s_rdata  = 32'hBBBB_0002;
        #1;
        chk("t4_lsu_addr", {2'b0, s_araddr}, {2'b0, 32'h8000_2000});
        tick();
        lsu_arvalid = 0;
        s_rvalid    = 0;
        #1;
        chk("t4_idle", {32'b0, grant}, 34'd0);

        // Asynchronous reset with a write response pending
        tick();
        push(EV_GNT, 34'd3);
        lsu_awvalid = 1;
        lsu_wvalid  = 1;
        lsu_awaddr  = 32'h8000_1004;
        lsu_wdata   = 32'h1234_5678;
        lsu_bready  = 0;
        s_awready   = 1;
        s_wready    = 1;
        tick();
        tick();
        lsu_awvalid = 0;
        lsu_wvalid  = 0;
        s_awready   = 0;
        s_wready    = 0;
        s_bvalid    = 1;
        #1;
        chk("t5_bvalid", {33'b0, lsu_bvalid}, 34'd1);
        chk("t5_grant", {32'b0, grant}, 34'd3);
        #1;
        rst = 1;
        #1;
        chk("t5_rst_grant", {32'b0, grant}, 34'd0);
        chk("t5_rst_bvalid", {33'b0, lsu_bvalid}, 34'd0);
        rst        = 0;
        s_bvalid   = 0;
        lsu_bready = 1;
        tick();
        push(EV_GNT, 34'd1);
        push(EV_IFU, {2'b00, 32'hCCCC_0003});
        push(EV_GNT, 34'd2);
        push(EV_LSR, {2'b00, 32'hCCCC_0003});
        ifu_arvalid = 1;
        lsu_arvalid = 1;
        s_arready   = 1;
        s_rvalid    = 1;
        s_rdata     = 32'hCCCC_0003;
        repeat (3) tick();
        ifu_arvalid = 0;
        lsu_arvalid = 0;
        tick();
        s_rvalid = 0;
        #1;
        chk("t5_idle", {32'b0, grant}, 34'd0);

        // LSU read answered in the same cycle as AR
        tick();
        push(EV_GNT, 34'd2);
        push(EV_LSR, {2'b00, 32'hD00D_0004});
        lsu_arvalid = 1;
        lsu_araddr  = 32'h8000_3000;
        s_arready   = 1;
        s_rvalid    = 1;
        s_rdata     = 32'hD00D_0004;
        tick();
        lsu_arvalid = 0;
        #1;
        chk("t6_rdata", {2'b0, lsu_rdata}, {2'b0, 32'hD00D_0004});
        tick();
        s_rvalid = 0;
        #1;
        chk("t6_idle", {32'b0, grant}, 34'd0);

        repeat (2) tick();
        chk("sb_empty", 34'(sb.size()), 34'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
